// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA constants, decoded-bundle type and branch-condition helper
package isa_pkg;

  localparam logic [3:0] HI_RTYPE = 4'h0;
  localparam logic [3:0] HI_ANDI  = 4'h1;
  localparam logic [3:0] HI_ORI   = 4'h2;
  localparam logic [3:0] HI_XORI  = 4'h3;
  localparam logic [3:0] HI_MEM   = 4'h4;
  localparam logic [3:0] HI_ADDI  = 4'h5;
  localparam logic [3:0] HI_ADDUI = 4'h6;
  localparam logic [3:0] HI_ADDCI = 4'h7;
  localparam logic [3:0] HI_SHIFT = 4'h8;
  localparam logic [3:0] HI_SUBI  = 4'h9;
  localparam logic [3:0] HI_SUBCI = 4'hA;
  localparam logic [3:0] HI_CMPI  = 4'hB;
  localparam logic [3:0] HI_CMPUI = 4'hC;
  localparam logic [3:0] HI_BCOND = 4'hE;
  localparam logic [3:0] HI_LUI   = 4'hF;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_CMPU  = 8'h0C;
  localparam logic [7:0] OP_LOAD  = 8'h40;
  localparam logic [7:0] OP_STOR  = 8'h44;
  localparam logic [7:0] OP_JALR  = 8'h48;
  localparam logic [7:0] OP_JCOND = 8'h4C;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_P = 2'b10;
  localparam logic [1:0] TYPE_J = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;

  // Width-independent part of a decoded instruction; imm and target travel beside it.
  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] rdest;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [1:0] typ;
    logic       wb;
    logic       illegal;
    logic       is_cond;
    logic [3:0] cond;
    logic       taken;
  } bundle_t;

  // flags ordered {Z,C,F,L,N}
  function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] flags);
    logic z, c, f, l, n;
    {z, c, f, l, n} = flags;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_HI: cond_true = l;
      COND_LS: cond_true = !l;
      COND_GT: cond_true = n;
      COND_LE: cond_true = !n;
      COND_FS: cond_true = f;
      COND_FC: cond_true = !f;
      COND_LO: cond_true = !l && !z;
      COND_HS: cond_true = l || z;
      COND_LT: cond_true = !n && !z;
      COND_GE: cond_true = n || z;
      COND_UC: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - DEPTH-entry synchronous FIFO with flush and registered status flags
module decode_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_in_ready, r_out_valid;
  logic          w_push, w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_push    = in_valid && r_in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (flush) w_count_nxt = '0;
    else       w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  // Status flags are registered from the next count so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= w_count_nxt < FULL;
      r_out_valid <= w_count_nxt != '0;
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= in_data;
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decode at enqueue, queue bundles, resolve branch conditions at the head
module decode_queue
  import isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [4:0]        flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [3:0]        out_rdest,
  output logic [3:0]        out_srcA,
  output logic [3:0]        out_srcB,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_type,
  output logic              out_wb,
  output logic              out_taken,
  output logic [PC_W-1:0]   out_target,
  output logic              out_illegal
);

  localparam int W = $bits(bundle_t) + DATA_W + PC_W;

  logic [3:0]        w_hi;
  bundle_t           w_dec, w_head;
  logic [DATA_W-1:0] w_imm, w_head_imm;
  logic [PC_W-1:0]   w_target, w_head_tgt;
  logic [W-1:0]      w_rd_data;
  logic              w_taken;

  assign w_hi = in_instr[15:12];

  always_comb begin
    w_dec        = '0;
    w_imm        = '0;
    w_target     = '0;
    w_dec.opcode = {in_instr[15:12], in_instr[7:4]};
    case (w_hi)
      HI_ANDI, HI_ORI, HI_XORI, HI_ADDI, HI_ADDUI, HI_ADDCI,
      HI_SUBI, HI_SUBCI, HI_CMPI, HI_CMPUI: begin
        w_dec.typ   = TYPE_I;
        w_dec.rdest = in_instr[11:8];
        w_dec.src_a = in_instr[11:8];
        w_dec.wb    = (w_hi != HI_CMPI) && (w_hi != HI_CMPUI);
        w_imm       = DATA_W'($signed(in_instr[7:0]));
      end
      HI_RTYPE: begin
        w_dec.rdest = in_instr[11:8];
        w_dec.src_a = in_instr[11:8];
        w_dec.src_b = in_instr[3:0];
        w_dec.wb    = (w_dec.opcode != OP_NOP) && (w_dec.opcode != OP_CMP) &&
                      (w_dec.opcode != OP_CMPU);
      end
      HI_SHIFT: begin
        w_dec.rdest = in_instr[11:8];
        w_dec.src_a = in_instr[11:8];
        if (!in_instr[6]) begin
          w_dec.typ = TYPE_I;
          w_dec.wb  = 1'b1;
          w_imm     = DATA_W'(in_instr[4:0]);
        end else if (!in_instr[7]) begin
          w_dec.src_b = in_instr[3:0];
          w_dec.wb    = 1'b1;
        end else begin
          w_dec.rdest   = '0;
          w_dec.src_a   = '0;
          w_dec.illegal = 1'b1;
        end
      end
      HI_MEM: begin
        w_dec.src_b = in_instr[3:0];
        case (w_dec.opcode)
          OP_LOAD:  begin w_dec.typ = TYPE_P; w_dec.rdest = in_instr[11:8]; w_dec.wb = 1'b1; end
          OP_STOR:  begin w_dec.typ = TYPE_P; w_dec.src_a = in_instr[11:8]; end
          OP_JALR:  begin
            w_dec.typ   = TYPE_J;
            w_dec.taken = 1'b1;
            w_dec.rdest = in_instr[11:8];
            w_dec.wb    = 1'b1;
          end
          OP_JCOND: begin w_dec.is_cond = 1'b1; w_dec.cond = in_instr[11:8]; end
          default:  begin w_dec.src_b = '0; w_dec.illegal = 1'b1; end
        endcase
      end
      HI_BCOND: begin
        w_dec.is_cond = 1'b1;
        w_dec.cond    = in_instr[11:8];
        w_target      = in_pc + PC_W'($signed(in_instr[7:0]));
      end
      HI_LUI: begin
        w_dec.typ   = TYPE_I;
        w_dec.rdest = in_instr[11:8];
        w_dec.wb    = 1'b1;
        w_imm       = DATA_W'({in_instr[7:0], 8'h00});
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  decode_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({w_dec, w_imm, w_target}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_rd_data)
  );

  assign {w_head, w_head_imm, w_head_tgt} = w_rd_data;
  // Conditional jumps read the live flags at the head, not the flags seen at enqueue.
  assign w_taken = w_head.is_cond ? cond_true(w_head.cond, flags) : w_head.taken;

  always_comb begin
    out_opcode  = '0;
    out_rdest   = '0;
    out_srcA    = '0;
    out_srcB    = '0;
    out_imm     = '0;
    out_type    = TYPE_R;
    out_wb      = 1'b0;
    out_taken   = 1'b0;
    out_target  = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_opcode  = w_head.opcode;
      out_rdest   = w_head.rdest;
      out_srcA    = w_head.src_a;
      out_srcB    = w_head.src_b;
      out_imm     = w_head_imm;
      out_type    = w_head.is_cond ? (w_taken ? TYPE_J : TYPE_R) : w_head.typ;
      out_wb      = w_head.wb;
      out_taken   = w_taken;
      out_target  = w_head_tgt;
      out_illegal = w_head.illegal;
    end
  end

endmodule
